// File: rtl/linebuf_pkg.sv
// linebuf_pkg: shared defaults and helpers for the multi-tap line buffer and its storage.
// Covers delay-width and tap-word-width derivation, delay clamping and tap slice positions.
package linebuf_pkg;

  localparam int unsigned LB_WIDTH_DEF     = 8;
  localparam int unsigned LB_MAX_DELAY_DEF = 1024;
  localparam int unsigned LB_TAPS_DEF      = 3;
  localparam int unsigned LB_MIN_DELAY     = 2;

  // Bits needed to hold a line length in the range 0..max_delay.
  function automatic int unsigned delay_width(input int unsigned max_delay);
    return $clog2(max_delay + 1);
  endfunction

  // The RAM keeps every tap except the newest one, which comes straight from the input.
  function automatic int unsigned tap_word_width(input int unsigned taps, input int unsigned width);
    return (taps - 1) * width;
  endfunction

  localparam int unsigned LB_DELAY_W_DEF = delay_width(LB_MAX_DELAY_DEF);
  localparam int unsigned LB_WORD_W_DEF  = tap_word_width(LB_TAPS_DEF, LB_WIDTH_DEF);

  // A line length below 2 would make the prefetch read and the write hit the same address.
  function automatic int unsigned clamp_delay(input int unsigned d, input int unsigned max_delay);
    if (d < LB_MIN_DELAY) return LB_MIN_DELAY;
    if (d > max_delay)    return max_delay;
    return d;
  endfunction

  function automatic int unsigned tap_lsb(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/linebuf_taps_ptr.sv
// linebuf_taps_ptr: wrapping address counter with synchronous clear and programmable last value.
// Exposes the next value so a synchronous RAM can be prefetched one cycle ahead.
module linebuf_taps_ptr
  import linebuf_pkg::*;
#(
  parameter int unsigned W_P = LB_DELAY_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clr,
  input  logic           i_inc,
  input  logic [W_P-1:0] i_last,
  output logic [W_P-1:0] o_cnt,
  output logic [W_P-1:0] o_cnt_nxt
);

  logic [W_P-1:0] r_cnt;

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    o_cnt_nxt = r_cnt;
    if (i_clr) begin
      o_cnt_nxt = '0;
    end else if (i_inc) begin
      o_cnt_nxt = (r_cnt == i_last) ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= o_cnt_nxt;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/sync_ram_block.sv
// sync_ram_block: simple dual-port RAM, one write and one registered read port.
// The read register holds its value whenever no read is issued.
module sync_ram_block
  import linebuf_pkg::*;
#(
  parameter int unsigned WIDTH_P = LB_WORD_W_DEF,
  parameter int unsigned DEPTH_P = LB_MAX_DELAY_DEF
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH_P)-1:0] i_waddr,
  input  logic [WIDTH_P-1:0]         i_wdata,
  input  logic                       i_re,
  input  logic [$clog2(DEPTH_P)-1:0] i_raddr,
  output logic [WIDTH_P-1:0]         o_rdata
);

  logic [WIDTH_P-1:0] r_mem [DEPTH_P];

  // NOTE: the array and its read register carry no reset so they map onto block RAM;
  // consumers must treat contents as undefined until written.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/linebuf_taps.sv
// linebuf_taps: multi-tap RAM line buffer emitting TAPS_P vertically aligned samples per accept.
// Define LINEBUF_PRIME_GATE_EN to suppress outputs until the first fully populated window.
module linebuf_taps
  import linebuf_pkg::*;
#(
  parameter int unsigned WIDTH_P     = LB_WIDTH_DEF,
  parameter int unsigned MAX_DELAY_P = LB_MAX_DELAY_DEF,
  parameter int unsigned TAPS_P      = LB_TAPS_DEF
) (
  input  logic                             clk_i,
  input  logic                             rstn_i,
  input  logic                             flush_i,
  input  logic [$clog2(MAX_DELAY_P+1)-1:0] delay_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  input  logic [WIDTH_P-1:0]               data_i,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [TAPS_P*WIDTH_P-1:0]        data_o,
  output logic                             primed_o
);

  localparam int unsigned DW     = delay_width(MAX_DELAY_P);
  localparam int unsigned AW     = $clog2(MAX_DELAY_P);
  localparam int unsigned FW     = $clog2(TAPS_P * MAX_DELAY_P + 1);
  localparam int unsigned WORD_W = tap_word_width(TAPS_P, WIDTH_P);
  localparam int unsigned OUT_W  = TAPS_P * WIDTH_P;

  logic [DW-1:0]     r_delay_q;
  logic [FW-1:0]     r_fill;
  logic              r_valid;
  logic              r_flush_d;
  logic [OUT_W-1:0]  r_data;

  logic [AW-1:0]     w_ptr;
  logic [AW-1:0]     w_ptr_nxt;
  logic [AW-1:0]     w_last;
  logic [WORD_W-1:0] w_rd_word;
  logic [OUT_W-1:0]  w_shift;
  logic [OUT_W-1:0]  w_taps;
  logic [FW-1:0]     w_fill_sat;
  logic              w_acc;
  logic              w_rd_en;
  logic              w_emit;

  // The cycle after a flush is spent prefetching address 0, so no accept is allowed.
  assign ready_o = (~r_valid | ready_i) & ~flush_i & ~r_flush_d;
  assign w_acc   = valid_i & ready_o;

  assign w_last     = AW'(r_delay_q - DW'(1));
  assign w_fill_sat = FW'(TAPS_P) * FW'(r_delay_q);
  assign w_rd_en    = w_acc | r_flush_d;

  linebuf_taps_ptr #(
    .W_P(AW)
  ) u_ptr (
    .clk      (clk_i),
    .rst_n    (rstn_i),
    .i_clr    (flush_i),
    .i_inc    (w_acc),
    .i_last   (w_last),
    .o_cnt    (w_ptr),
    .o_cnt_nxt(w_ptr_nxt)
  );

  // Each stored word is the previous line's word shifted up by one tap with the new sample at the bottom.
  assign w_shift = {w_rd_word, data_i};

  sync_ram_block #(
    .WIDTH_P(WORD_W),
    .DEPTH_P(MAX_DELAY_P)
  ) u_ram (
    .clk    (clk_i),
    .i_we   (w_acc),
    .i_waddr(w_ptr),
    .i_wdata(w_shift[WORD_W-1:0]),
    .i_re   (w_rd_en),
    .i_raddr(w_ptr_nxt),
    .o_rdata(w_rd_word)
  );

  // RAM is never cleared, so taps older than the data seen since restart are forced to zero.
  always_comb begin
    w_taps = w_shift;
    for (int unsigned k = 1; k < TAPS_P; k++) begin
      if (r_fill < FW'(k) * FW'(r_delay_q)) begin
        w_taps[tap_lsb(k, WIDTH_P) +: WIDTH_P] = '0;
      end
    end
  end

`ifdef LINEBUF_PRIME_GATE_EN
  logic [FW-1:0] w_fill_win;
  // A window is complete once the oldest tap is no longer masked.
  assign w_fill_win = FW'(TAPS_P - 1) * FW'(r_delay_q);
  assign w_emit     = (r_fill >= w_fill_win);
`else
  assign w_emit = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_delay_q <= DW'(MAX_DELAY_P);
      r_fill    <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_flush_d <= 1'b0;
    end else begin
      r_flush_d <= flush_i;
      if (flush_i) begin
        r_delay_q <= DW'(clamp_delay(32'(delay_i), MAX_DELAY_P));
        r_fill    <= '0;
        r_valid   <= 1'b0;
        r_data    <= '0;
      end else if (w_acc) begin
        if (r_fill < w_fill_sat) r_fill <= r_fill + 1'b1;
        r_valid <= w_emit;
        r_data  <= w_taps;
      end else if (ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign valid_o  = r_valid;
  assign data_o   = r_data;
  assign primed_o = (r_fill == w_fill_sat);

endmodule

// File: tb/tb_linebuf_taps.sv
// tb_linebuf_taps: directed bench for linebuf_taps (TAPS_P=3, MAX_DELAY_P=16) with a tap model and scoreboard.
// Also builds with LINEBUF_PRIME_GATE_EN defined, where early windows are expected to be suppressed.
module tb_linebuf_taps;

  localparam int unsigned W    = 8;
  localparam int unsigned MAXD = 16;
  localparam int unsigned TAPS = 3;
  localparam int unsigned DW   = $clog2(MAXD + 1);
  localparam int unsigned OW   = TAPS * W;

  logic          clk = 1'b0;
  logic          rstn_i;
  logic          flush_i;
  logic [DW-1:0] delay_i;
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  data_i;
  logic          valid_o;
  logic          ready_i;
  logic [OW-1:0] data_o;
  logic          primed_o;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]  sv[$];
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] got_q[$];
  int            cur_d;
  bit            toggle_rdy = 1'b0;
  bit            stalled = 1'b0;
  logic [OW-1:0] stall_data = '0;

  linebuf_taps #(
    .WIDTH_P    (W),
    .MAX_DELAY_P(MAXD),
    .TAPS_P     (TAPS)
  ) dut (
    .clk_i   (clk),
    .rstn_i  (rstn_i),
    .flush_i (flush_i),
    .delay_i (delay_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .primed_o(primed_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output collector and hold-while-stalled checker, sampled on the falling edge.
  always @(negedge clk) begin
    if (rstn_i === 1'b1) begin
      if (stalled && valid_o) check("stall_hold", data_o, stall_data);
      if (valid_o && ready_i) got_q.push_back(data_o);
    end
    stalled    = (rstn_i === 1'b1) && valid_o && !ready_i;
    stall_data = data_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_rdy) ready_i = !ready_i;
  endtask

  // Expected taps for the newest sample: tap k is the sample k*cur_d accepts earlier, or 0.
  task automatic model_push(input logic [W-1:0] v);
    int n;
    logic [OW-1:0] w;
    sv.push_back(v);
    n = sv.size() - 1;
    w = '0;
    w[W-1:0] = v;
    for (int k = 1; k < TAPS; k++) begin
      if (n >= k * cur_d) w[k*W +: W] = sv[n - k*cur_d];
    end
`ifdef LINEBUF_PRIME_GATE_EN
    if (n >= (TAPS - 1) * cur_d) exp_q.push_back(w);
`else
    exp_q.push_back(w);
`endif
  endtask

  task automatic push(input logic [W-1:0] v);
    bit done = 1'b0;
    valid_i = 1'b1;
    data_i  = v;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      done = ready_o;
      tick();
    end
    check("push_accept", done, 1'b1);
    if (done) model_push(v);
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_flush(input int d, input int clamped);
    valid_i = 1'b0;
    flush_i = 1'b1;
    delay_i = DW'(d);
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_ready_low", ready_o, 1'b0);
    check("flush_valid_low", valid_o, 1'b0);
    tick();
    cur_d = clamped;
    sv.delete();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic drain_and_score(input string tag);
    toggle_rdy = 1'b0;
    ready_i    = 1'b1;
    idle(4);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check(tag, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn_i  = 1'b0;
    flush_i = 1'b0;
    delay_i = '0;
    valid_i = 1'b0;
    data_i  = '0;
    ready_i = 1'b1;
    cur_d   = MAXD;

    // Reset state.
    #12;
    check("rst_valid", valid_o, 1'b0);
    check("rst_data", data_o, '0);
    check("rst_primed", primed_o, 1'b0);
    @(negedge clk);
    rstn_i = 1'b1;
    tick();
    check("rst_ready", ready_o, 1'b1);

    // Delay 4, unstalled stream 0..15.
    do_flush(4, 4);
    for (int i = 0; i < 16; i++) begin
      push(W'(i));
`ifdef LINEBUF_PRIME_GATE_EN
      if (i == 7) check("gate_none_before", valid_o, 1'b0);
      if (i == 8) begin
        check("gate_first_valid", valid_o, 1'b1);
        check("gate_first_taps", data_o, 24'h000408);
      end
`else
      if (i == 0) check("latency_valid", valid_o, 1'b1);
`endif
      if (i == 5)  check("s5_taps", data_o, 24'h000105);
      if (i == 12) check("s12_taps", data_o, 24'h04080c);
      if (i == 10) check("primed_before", primed_o, 1'b0);
      if (i == 11) check("primed_at_s11", primed_o, 1'b1);
    end
    drain_and_score("stream_d4");

    // Same stream with ready_i toggling and random input gaps.
    do_flush(4, 4);
    toggle_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      idle($urandom_range(0, 2));
      push(W'(i));
    end
    drain_and_score("stream_d4_stall");

    // Delay below minimum clamps to 2.
    do_flush(1, 2);
    for (int i = 0; i < 8; i++) begin
      push(W'(8'h10 + i));
      if (i == 3) check("d2_s3_taps", data_o, 24'h001113);
      if (i == 4) check("d2_s4_taps", data_o, 24'h101214);
      if (i == 4) check("d2_primed_before", primed_o, 1'b0);
      if (i == 5) check("d2_primed", primed_o, 1'b1);
    end
    drain_and_score("stream_d2");

    // Delay above maximum clamps to MAXD.
    do_flush(MAXD + 5, MAXD);
    for (int i = 0; i < 48; i++) begin
      push(W'(8'h40 + i));
      if (i == 31) check("dmax_s31_taps", data_o, 24'h004f5f);
      if (i == 32) check("dmax_s32_taps", data_o, 24'h405060);
      if (i == 46) check("dmax_primed_before", primed_o, 1'b0);
      if (i == 47) check("dmax_primed", primed_o, 1'b1);
    end
    drain_and_score("stream_dmax");

    // Mid-stream flush coincident with valid input and an unconsumed output.
    do_flush(4, 4);
    for (int i = 0; i < 6; i++) push(W'(8'ha0 + i));
    ready_i = 1'b0;
    flush_i = 1'b1;
    delay_i = DW'(4);
    valid_i = 1'b1;
    data_i  = 8'hee;
    @(negedge clk);
    check("mflush_ready_low", ready_o, 1'b0);
`ifndef LINEBUF_PRIME_GATE_EN
    check("mflush_valid_pending", valid_o, 1'b1);
    void'(exp_q.pop_back());
`endif
    tick();
    flush_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    check("mflush_valid_cleared", valid_o, 1'b0);
    check("mflush_prefetch_ready", ready_o, 1'b0);
    tick();
    drain_and_score("pre_flush");
    cur_d = 4;
    sv.delete();
    for (int i = 0; i < 5; i++) begin
      push(W'(8'hb0 + i));
      if (i == 0) check("mflush_s0_masked", data_o, 24'h0000b0);
      if (i == 4) check("mflush_s4_masked", data_o, 24'h00b0b4);
    end
    drain_and_score("post_flush");

    // Asynchronous reset mid-stream while an output is stalled.
    do_flush(4, 4);
    for (int i = 0; i < 12; i++) push(W'(8'hc0 + i));
    ready_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check("prereset_primed", primed_o, 1'b1);
    check("prereset_valid", valid_o, 1'b1);
    #2;
    rstn_i = 1'b0;
    #1;
    check("async_rst_valid", valid_o, 1'b0);
    check("async_rst_primed", primed_o, 1'b0);
    check("async_rst_data", data_o, '0);
    @(negedge clk);
    rstn_i = 1'b1;
    ready_i = 1'b1;
    cur_d = MAXD;
    sv.delete();
    exp_q.delete();
    got_q.delete();
    tick();
    check("postreset_ready", ready_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      push(W'(8'hd0 + i));
      if (i == 0) check("postreset_s0", data_o, 24'h0000d0);
      if (i == 2) check("postreset_s2", data_o, 24'h0000d2);
    end
    drain_and_score("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
